// File: rtl/nios2_ocimem_pkg.sv
// rtl/nios2_ocimem_pkg.sv - shared constants and helpers for the OCIMEM controller.
package nios2_ocimem_pkg;

  localparam int ADDR_LSB    = 17;
  localparam int LOAD_BIT    = 17;
  localparam int RD_BIT      = 35;
  localparam int CLR_ERR_BIT = 28;
  localparam int WDATA_MSB   = 34;
  localparam int WDATA_LSB   = 3;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] JACC = 2'd1;
  localparam logic [1:0] JCAP = 2'd2;

  function automatic logic parity32(input logic [31:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/nios2_ocimem_ram.sv
// rtl/nios2_ocimem_ram.sv - single-port, synchronous-read, byte-enabled OCIMEM array.
module nios2_ocimem_ram
  import nios2_ocimem_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int WIDTH  = 32
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  input  logic              we,
  input  logic [3:0]        be,
  input  logic [31:0]       wdata,
  output logic [WIDTH-1:0]  q
);

  logic [WIDTH-1:0] mem [2**ADDR_W];
  logic [31:0]      merged;

  // Byte writes merge with the stored word so a 33-bit word carries parity of the full result.
  always_comb begin
    merged = mem[addr][31:0];
    for (int i = 0; i < 4; i++) begin
      if (be[i]) merged[8*i +: 8] = wdata[8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= WIDTH'({parity32(merged), merged});
    q <= mem[addr];
  end

endmodule

// File: rtl/nios2_ocimem_ctrl.sv
// rtl/nios2_ocimem_ctrl.sv - OCIMEM controller: JTAG debug commands with priority over an Avalon-MM CPU port.
// OCIMEM_PARITY_EN stores an even-parity bit per word and flags mismatches on read via monitor_error.
module nios2_ocimem_ctrl
  import nios2_ocimem_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_no_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic [ADDR_W-1:0] avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  input  logic [3:0]        avs_byteenable,
  output logic              avs_waitrequest,
  output logic [31:0]       avs_readdata,
  output logic              avs_readdatavalid,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error
);

`ifdef OCIMEM_PARITY_EN
  localparam int RAM_W = 33;
`else
  localparam int RAM_W = 32;
`endif

  logic [1:0]        state;
  logic [ADDR_W-1:0] mon_a_reg;
  logic              rd_pend, inc_pend;
  logic [RAM_W-1:0]  ram_q;
  logic              idle, any_pulse, multi_pulse;
  logic              acc_a, acc_na, acc_b, addr_load, jtag_rd, jtag_go;
  logic              cpu_rd, cpu_wr, set_err, clr_err, parity_err;
  logic [ADDR_W-1:0] jtag_addr;
  logic              unused_jdo;

  assign idle        = (state == IDLE);
  assign any_pulse   = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
  assign multi_pulse = (take_action_ocimem_b & take_action_ocimem_a) |
                       (take_action_ocimem_b & take_no_action_ocimem_a) |
                       (take_action_ocimem_a & take_no_action_ocimem_a);

  assign acc_b     = idle & take_action_ocimem_b;
  assign acc_a     = idle & take_action_ocimem_a & ~take_action_ocimem_b;
  assign acc_na    = idle & take_no_action_ocimem_a & ~take_action_ocimem_b & ~take_action_ocimem_a;
  assign addr_load = acc_a & jdo[LOAD_BIT];
  assign jtag_rd   = (acc_a & jdo[RD_BIT]) | acc_na;
  assign jtag_go   = jtag_rd | acc_b;

  // The JTAG access is presented to the RAM in the pulse cycle itself, so a load+read uses the new address.
  assign jtag_addr = addr_load ? jdo[ADDR_LSB +: ADDR_W] : mon_a_reg;

  assign avs_waitrequest = any_pulse | ~idle;
  assign cpu_wr          = avs_write & ~avs_waitrequest;
  assign cpu_rd          = avs_read & ~avs_write & ~avs_waitrequest;
  assign avs_readdata    = avs_readdatavalid ? ram_q[31:0] : 32'd0;

`ifdef OCIMEM_PARITY_EN
  assign parity_err = ((state == JACC && rd_pend) || avs_readdatavalid) &&
                      (ram_q[32] != parity32(ram_q[31:0]));
`else
  assign parity_err = 1'b0;
`endif

  assign set_err    = (any_pulse & ~idle) | (idle & multi_pulse) | parity_err;
  assign clr_err    = acc_a & jdo[CLR_ERR_BIT];
  assign unused_jdo = ^jdo;

  nios2_ocimem_ram #(
    .ADDR_W (ADDR_W),
    .WIDTH  (RAM_W)
  ) u_ram (
    .clk   (clk),
    .addr  (jtag_go ? jtag_addr : avs_address),
    .we    (acc_b | cpu_wr),
    .be    (acc_b ? 4'hF : avs_byteenable),
    .wdata (acc_b ? jdo[WDATA_MSB:WDATA_LSB] : avs_writedata),
    .q     (ram_q)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state             <= IDLE;
      mon_a_reg         <= '0;
      MonDReg           <= '0;
      monitor_ready     <= 1'b0;
      monitor_error     <= 1'b0;
      avs_readdatavalid <= 1'b0;
      rd_pend           <= 1'b0;
      inc_pend          <= 1'b0;
    end else begin
      avs_readdatavalid <= cpu_rd;
      monitor_error     <= (monitor_error & ~clr_err) | set_err;
      case (state)
        IDLE: begin
          if (jtag_go) begin
            state    <= JACC;
            rd_pend  <= jtag_rd;
            inc_pend <= acc_b | acc_na;
          end
          if (addr_load) mon_a_reg <= jdo[ADDR_LSB +: ADDR_W];
          if (any_pulse) monitor_ready <= acc_a & ~jdo[RD_BIT];
        end
        JACC: begin
          state         <= JCAP;
          monitor_ready <= 1'b1;
          if (rd_pend) MonDReg <= ram_q[31:0];
          if (inc_pend) mon_a_reg <= mon_a_reg + ADDR_W'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nios2_ocimem_ctrl.sv
// tb/tb_nios2_ocimem_ctrl.sv - directed and randomized bench for nios2_ocimem_ctrl.
module tb_nios2_ocimem_ctrl;
  localparam int ADDR_W = 8;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              reset;
  logic [37:0]       jdo;
  logic              take_a, take_na, take_b;
  logic [ADDR_W-1:0] avs_address;
  logic              avs_read, avs_write;
  logic [31:0]       avs_writedata;
  logic [3:0]        avs_byteenable;
  logic              avs_waitrequest;
  logic [31:0]       avs_readdata;
  logic              avs_readdatavalid;
  logic [31:0]       MonDReg;
  logic              monitor_ready, monitor_error;

  int checks = 0;
  int errors = 0;

  logic [31:0]       model_mem [DEPTH];
  logic [ADDR_W-1:0] model_addr;
  logic [31:0]       model_mon;
  logic              model_err;

  nios2_ocimem_ctrl #(.ADDR_W(ADDR_W)) dut (
    .clk                     (clk),
    .reset                   (reset),
    .jdo                     (jdo),
    .take_action_ocimem_a    (take_a),
    .take_no_action_ocimem_a (take_na),
    .take_action_ocimem_b    (take_b),
    .avs_address             (avs_address),
    .avs_read                (avs_read),
    .avs_write               (avs_write),
    .avs_writedata           (avs_writedata),
    .avs_byteenable          (avs_byteenable),
    .avs_waitrequest         (avs_waitrequest),
    .avs_readdata            (avs_readdata),
    .avs_readdatavalid       (avs_readdatavalid),
    .MonDReg                 (MonDReg),
    .monitor_ready           (monitor_ready),
    .monitor_error           (monitor_error)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] be);
    logic [31:0] mask;
    mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    return (old & ~mask) | (nw & mask);
  endfunction

  function automatic logic [37:0] mk_a(input bit load, input logic [7:0] addr, input bit rd, input bit clr);
    logic [37:0] j;
    j = '0;
    if (load) j[17 +: ADDR_W] = addr;
    j[17] = load;
    j[35] = rd;
    j[28] = clr;
    return j;
  endfunction

  function automatic logic [37:0] mk_b(input logic [31:0] d);
    logic [37:0] j;
    j = '0;
    j[34:3] = d;
    return j;
  endfunction

  // Drives one cycle of pulses; returns at the negedge of cycle T+1.
  task automatic pulse(input bit a, input bit na, input bit b, input logic [37:0] j);
    @(negedge clk);
    jdo = j; take_a = a; take_na = na; take_b = b;
    @(negedge clk);
    take_a = 0; take_na = 0; take_b = 0; jdo = '0;
    #1;
  endtask

  task automatic check_state(input string tag);
    check({tag, "_mondreg"}, MonDReg, model_mon);
    check({tag, "_ready"}, monitor_ready, 1'b1);
    check({tag, "_error"}, monitor_error, model_err);
    check({tag, "_areg"}, dut.mon_a_reg, model_addr);
  endtask

  // kind: 0 = action_a, 1 = no_action_a (read-next), 2 = action_b (write)
  task automatic jtag_cmd(input int kind, input logic [37:0] j, input string tag);
    pulse(kind == 0, kind == 1, kind == 2, j);
    repeat (2) @(negedge clk);
    case (kind)
      0: begin
        if (j[17]) model_addr = j[17 +: ADDR_W];
        if (j[35]) model_mon = model_mem[model_addr];
        if (j[28]) model_err = 1'b0;
      end
      1: begin
        model_mon = model_mem[model_addr];
        model_addr++;
      end
      default: begin
        model_mem[model_addr] = j[34:3];
        model_addr++;
      end
    endcase
    check_state(tag);
  endtask

  task automatic cpu_write(input logic [ADDR_W-1:0] a, input logic [31:0] d, input logic [3:0] be);
    int n = 0;
    @(negedge clk);
    avs_address = a; avs_writedata = d; avs_byteenable = be; avs_write = 1; #1;
    while (avs_waitrequest && n < 20) begin @(negedge clk); #1; n++; end
    @(negedge clk);
    avs_write = 0;
    model_mem[a] = merge(model_mem[a], d, be);
  endtask

  task automatic cpu_read(input logic [ADDR_W-1:0] a, input string tag);
    int n = 0;
    @(negedge clk);
    avs_address = a; avs_read = 1; #1;
    while (avs_waitrequest && n < 20) begin @(negedge clk); #1; n++; end
    check({tag, "_accept"}, n < 20, 1'b1);
    @(negedge clk);
    avs_read = 0;
    check({tag, "_rvalid"}, avs_readdatavalid, 1'b1);
    check({tag, "_rdata"}, avs_readdata, model_mem[a]);
  endtask

  initial begin
    logic [31:0] d;
    logic [7:0]  a;
    int          n;
    reset = 1; jdo = '0; take_a = 0; take_na = 0; take_b = 0;
    avs_address = '0; avs_read = 0; avs_write = 0; avs_writedata = '0; avs_byteenable = '0;
    model_addr = '0; model_mon = '0; model_err = 0;
    repeat (3) @(negedge clk);
    check("rst_mondreg", MonDReg, 32'd0);
    check("rst_ready", monitor_ready, 1'b0);
    check("rst_error", monitor_error, 1'b0);
    check("rst_rvalid", avs_readdatavalid, 1'b0);
    check("rst_rdata", avs_readdata, 32'd0);
    check("rst_areg", dut.mon_a_reg, 8'h00);
    reset = 0;
    @(negedge clk); #1;
    check("idle_waitreq", avs_waitrequest, 1'b0);

    // Address load, write, and read-back with explicit cycle timing.
    pulse(1, 0, 0, mk_a(1, 8'h11, 0, 0));
    check("t1_addr_only_ready_t1", monitor_ready, 1'b1);
    check("t1_addr_only_areg", dut.mon_a_reg, 8'h11);
    model_addr = 8'h11;
    pulse(0, 0, 1, mk_b(32'hDEADBEEF));
    check("t1_wr_ready_t1", monitor_ready, 1'b0);
    check("t1_wr_waitreq_t1", avs_waitrequest, 1'b1);
    @(negedge clk);
    check("t1_wr_ready_t2", monitor_ready, 1'b1);
    check("t1_wr_areg_t2", dut.mon_a_reg, 8'h12);
    @(negedge clk);
    model_mem[8'h11] = 32'hDEADBEEF; model_addr = 8'h12;
    pulse(1, 0, 0, mk_a(1, 8'h11, 1, 0));
    check("t1_rd_ready_t1", monitor_ready, 1'b0);
    @(negedge clk);
    check("t1_rd_mondreg_t2", MonDReg, 32'hDEADBEEF);
    check("t1_rd_ready_t2", monitor_ready, 1'b1);
    check("t1_rd_areg", dut.mon_a_reg, 8'h11);
    @(negedge clk);
    model_addr = 8'h11; model_mon = 32'hDEADBEEF;

    // Read-next sweep.
    for (int i = 0; i < 4; i++) cpu_write(8'h21 + 8'(i), 32'(i + 1), 4'hF);
    jtag_cmd(0, mk_a(1, 8'h21, 0, 0), "t2_load");
    for (int i = 0; i < 4; i++) jtag_cmd(1, '0, $sformatf("t2_next%0d", i));
    check("t2_final_areg", dut.mon_a_reg, 8'h25);

    // Wrap from the top address.
    jtag_cmd(0, mk_a(1, 8'hFF, 0, 0), "t3_load");
    jtag_cmd(2, mk_b($urandom), "t3_write");
    check("t3_wrap_areg", dut.mon_a_reg, 8'h00);
    cpu_read(8'hFF, "t3_cpu");

    // Collision: a second pulse during JACC is dropped.
    jtag_cmd(0, mk_a(1, 8'h41, 0, 0), "t4_load");
    d = $urandom;
    @(negedge clk); take_b = 1; jdo = mk_b(d);
    @(negedge clk); take_b = 0; take_a = 1; jdo = mk_a(1, 8'h51, 1, 0);
    @(negedge clk); take_a = 0; jdo = '0;
    @(negedge clk);
    model_mem[8'h41] = d; model_addr = 8'h42; model_err = 1;
    check_state("t4_collide");
    jtag_cmd(0, mk_a(0, 8'h00, 0, 1), "t4_clear");
    d = $urandom;
    pulse(0, 1, 1, mk_b(d));
    repeat (2) @(negedge clk);
    model_mem[8'h42] = d; model_addr = 8'h43; model_err = 1;
    check_state("t4_b_over_na");
    jtag_cmd(0, mk_a(0, 8'h00, 0, 1), "t4_clear2");
    pulse(1, 1, 0, mk_a(1, 8'h41, 1, 0));
    repeat (2) @(negedge clk);
    model_addr = 8'h41; model_mon = model_mem[8'h41]; model_err = 1;
    check_state("t4_a_over_na");
    jtag_cmd(0, mk_a(0, 8'h00, 0, 1), "t4_clear3");

    // CPU read stalled behind a JTAG write to the same word.
    jtag_cmd(0, mk_a(1, 8'h31, 0, 0), "t5_load");
    d = $urandom;
    @(negedge clk);
    avs_address = 8'h31; avs_read = 1; take_b = 1; jdo = mk_b(d); #1;
    check("t5_waitreq_t0", avs_waitrequest, 1'b1);
    @(negedge clk);
    take_b = 0; jdo = '0; #1;
    check("t5_waitreq_t1", avs_waitrequest, 1'b1);
    check("t5_no_rvalid_t1", avs_readdatavalid, 1'b0);
    n = 0;
    while (avs_waitrequest && n < 20) begin @(negedge clk); #1; n++; end
    check("t5_stall_cycles", n, 2);
    @(negedge clk);
    avs_read = 0;
    check("t5_rvalid", avs_readdatavalid, 1'b1);
    check("t5_new_data", avs_readdata, d);
    model_mem[8'h31] = d; model_addr = 8'h32;

    // Byte-lane write and simultaneous read/write.
    cpu_write(8'h61, 32'h11223344, 4'hF);
    cpu_write(8'h61, 32'h000000AA, 4'b0001);
    cpu_read(8'h61, "t6_byte");
    check("t6_byte_value", model_mem[8'h61], 32'h112233AA);
    check("t6_no_error", monitor_error, 1'b0);
    d = $urandom;
    @(negedge clk);
    avs_address = 8'h62; avs_writedata = d; avs_byteenable = 4'hF; avs_read = 1; avs_write = 1;
    @(negedge clk);
    avs_read = 0; avs_write = 0;
    check("t6_rw_no_rvalid", avs_readdatavalid, 1'b0);
    model_mem[8'h62] = d;
    cpu_read(8'h62, "t6_rw_data");
`ifdef OCIMEM_PARITY_EN
    dut.u_ram.mem[8'h61][32] = ~dut.u_ram.mem[8'h61][32];
    cpu_read(8'h61, "t6_par");
    @(negedge clk);
    check("t6_parity_error", monitor_error, 1'b1);
    model_err = 1;
    jtag_cmd(0, mk_a(0, 8'h00, 0, 1), "t6_par_clear");
`endif

    // Randomized mix over an initialized region.
    for (int i = 0; i < 16; i++) cpu_write(8'h40 + 8'(i), $urandom, 4'hF);
    for (int i = 0; i < 40; i++) begin
      a = 8'h41 + 8'(2 * $urandom_range(0, 6));
      case ($urandom_range(0, 3))
        0: cpu_write(8'h40 + 8'($urandom_range(0, 15)), $urandom, 4'($urandom_range(0, 15)));
        1: cpu_read(8'h40 + 8'($urandom_range(0, 15)), $sformatf("rnd%0d_cpu", i));
        2: jtag_cmd(0, mk_a(1, a, 1, 0), $sformatf("rnd%0d_jrd", i));
        default: begin
          jtag_cmd(0, mk_a(1, a, 0, 0), $sformatf("rnd%0d_jld", i));
          jtag_cmd(2, mk_b($urandom), $sformatf("rnd%0d_jwr", i));
          jtag_cmd(1, '0, $sformatf("rnd%0d_jnx", i));
        end
      endcase
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
